logic_microop_controller: RTL and testbench



---
 rtl/logic_microop_controller.sv | 149 ++++++++++++++
 tb/tb_logic_microop_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_microop_controller.sv
// Register-to-register logic microoperation sequencer: a 4x4-bit register file
// feeding a 4-bit logic unit through a four-state IDLE/READ/EXEC/WB sequence.

// Combinational 4-bit logic unit: AND, OR, XOR, NOT A.
module logic_unit_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] sel,
  output logic [3:0] F
);

  // Select the logic function; B is unused for NOT A.
  always_comb begin
    F = 4'b0000;
    case (sel)
      2'b00:   F = A & B;
      2'b01:   F = A | B;
      2'b10:   F = A ^ B;
      default: F = ~A;
    endcase
  end

endmodule

module logic_microop_controller #(
  parameter logic [3:0] REG_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_dst,
  input  logic [1:0] cmd_srca,
  input  logic [1:0] cmd_srcb,
  input  logic [3:0] cmd_imm,
  output logic       done,
  output logic [3:0] result,
  output logic       zero,
  input  logic [1:0] rd_addr,
  output logic [3:0] rd_data
);

  localparam int unsigned DW   = 4;
  localparam int unsigned AW   = 2;
  localparam int unsigned NREG = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   regs [NREG];

  // Command fields captured at the handshake
  logic            c_load;
  logic [1:0]      c_op;
  logic [AW-1:0]   c_dst;
  logic [AW-1:0]   c_srca;
  logic [AW-1:0]   c_srcb;
  logic [DW-1:0]   c_imm;

  // Datapath pipeline registers
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [DW-1:0]   res;

  logic [DW-1:0]   lu_f;
  logic [DW-1:0]   next_res;

  logic_unit_4bit u_lu (
    .A   (op_a),
    .B   (op_b),
    .sel (c_op),
    .F   (lu_f)
  );

  assign next_res = c_load ? c_imm : lu_f;

  // Debug read port is a plain combinational view of the register file.
  assign rd_data = regs[rd_addr];

  // Sequencer, register file and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= REG_INIT;
      end
      c_load    <= 1'b0;
      c_op      <= 2'b00;
      c_dst     <= AW'(0);
      c_srca    <= AW'(0);
      c_srcb    <= AW'(0);
      c_imm     <= DW'(0);
      op_a      <= DW'(0);
      op_b      <= DW'(0);
      res       <= DW'(0);
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      result    <= DW'(0);
      zero      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            c_load    <= cmd_load;
            c_op      <= cmd_op;
            c_dst     <= cmd_dst;
            c_srca    <= cmd_srca;
            c_srcb    <= cmd_srcb;
            c_imm     <= cmd_imm;
            cmd_ready <= 1'b0;
            state     <= READ;
          end
        end
        READ: begin
          // Operands sampled before writeback, so aliased dst sees old data
          op_a  <= regs[c_srca];
          op_b  <= regs[c_srcb];
          state <= EXEC;
        end
        EXEC: begin
          // result/zero/done become visible during the WB cycle
          res    <= next_res;
          result <= next_res;
          zero   <= (next_res == DW'(0));
          done   <= 1'b1;
          state  <= WB;
        end
        WB: begin
          regs[c_dst] <= res;
          cmd_ready   <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_microop_controller.sv
// Directed self-checking bench for logic_microop_controller.
module tb_logic_microop_controller;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [1:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_srca;
  logic [1:0] cmd_srcb;
  logic [3:0] cmd_imm;
  logic       done;
  logic [3:0] result;
  logic       zero;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;

  int n_cmp;
  int n_fail;

  logic_microop_controller #(.REG_INIT(4'b0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_srca  (cmd_srca),
    .cmd_srcb  (cmd_srcb),
    .cmd_imm   (cmd_imm),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command; report cycles from handshake to done, and the WB-cycle view.
  // Returns at the negedge of the cycle after done (first IDLE cycle).
  task automatic issue(input logic ld, input logic [1:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] imm,
                       output int lat, output logic [3:0] res, output logic z,
                       output logic [3:0] old_rd);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    cmd_load  = ld;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_srca  = sa;
    cmd_srcb  = sb;
    cmd_imm   = imm;
    rd_addr   = dst;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = 99;
    res    = result;
    z      = zero;
    old_rd = rd_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_load = 1'b0; cmd_op = 2'b00; cmd_dst = 2'd0;
    cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_imm = 4'h0; rd_addr = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b exp 1", zero); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if (result !== 4'b0000) begin n_fail++; $display("FAIL reset_result got %b exp 0000", result); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      n_cmp++; if (rd_data !== 4'b0000) begin n_fail++; $display("FAIL reset_rd%0d got %b exp 0000", i, rd_data); end
    end
  endtask

  task automatic test_load();
    int lat; logic [3:0] r; logic z; logic [3:0] o;
    issue(1'b1, 2'b00, 2'd0, 2'd0, 2'd0, 4'b1010, lat, r, z, o);
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL load0_latency got %0d exp 3", lat); end
    n_cmp++; if (r !== 4'b1010) begin n_fail++; $display("FAIL load0_result got %b exp 1010", r); end
    n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL load0_zero got %b exp 0", z); end
    n_cmp++; if (rd_data !== 4'b1010) begin n_fail++; $display("FAIL load0_rd got %b exp 1010", rd_data); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL load0_done_single got %b exp 0", done); end
    issue(1'b1, 2'b00, 2'd1, 2'd0, 2'd0, 4'b1100, lat, r, z, o);
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL load1_latency got %0d exp 3", lat); end
    n_cmp++; if (r !== 4'b1100) begin n_fail++; $display("FAIL load1_result got %b exp 1100", r); end
    n_cmp++; if (rd_data !== 4'b1100) begin n_fail++; $display("FAIL load1_rd got %b exp 1100", rd_data); end
    rd_addr = 2'd0; #1;
    n_cmp++; if (rd_data !== 4'b1010) begin n_fail++; $display("FAIL load1_r0_kept got %b exp 1010", rd_data); end
  endtask

  task automatic test_logic_ops();
    int lat; logic [3:0] r; logic z; logic [3:0] o;
    logic [1:0]  ops [4];
    logic [1:0]  dsts [4];
    logic [1:0]  srcbs [4];
    logic [3:0]  exps [4];
    logic [3:0]  olds [4];
    ops   = '{2'b00, 2'b01, 2'b10, 2'b11};
    dsts  = '{2'd2, 2'd3, 2'd2, 2'd3};
    srcbs = '{2'd1, 2'd1, 2'd1, 2'd1};
    exps  = '{4'b1000, 4'b1110, 4'b0110, 4'b0101};
    olds  = '{4'b0000, 4'b0000, 4'b1000, 4'b1110};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, ops[i], dsts[i], 2'd0, srcbs[i], 4'b1111, lat, r, z, o);
      n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL op%0d_latency got %0d exp 3", i, lat); end
      n_cmp++; if (r !== exps[i]) begin n_fail++; $display("FAIL op%0d_result got %b exp %b", i, r, exps[i]); end
      n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL op%0d_zero got %b exp 0", i, z); end
      n_cmp++; if (o !== olds[i]) begin n_fail++; $display("FAIL op%0d_rd_in_wb got %b exp %b", i, o, olds[i]); end
      n_cmp++; if (rd_data !== exps[i]) begin n_fail++; $display("FAIL op%0d_rd_after got %b exp %b", i, rd_data, exps[i]); end
    end
    // NOT with a different B source must give the same answer
    issue(1'b0, 2'b11, 2'd3, 2'd0, 2'd2, 4'b0000, lat, r, z, o);
    n_cmp++; if (r !== 4'b0101) begin n_fail++; $display("FAIL not_b_dontcare got %b exp 0101", r); end
  endtask

  task automatic test_alias();
    int lat; logic [3:0] r; logic z; logic [3:0] o;
    issue(1'b0, 2'b10, 2'd0, 2'd0, 2'd0, 4'b1111, lat, r, z, o);
    n_cmp++; if (r !== 4'b0000) begin n_fail++; $display("FAIL alias_result got %b exp 0000", r); end
    n_cmp++; if (z !== 1'b1) begin n_fail++; $display("FAIL alias_zero got %b exp 1", z); end
    n_cmp++; if (o !== 4'b1010) begin n_fail++; $display("FAIL alias_rd_in_wb got %b exp 1010", o); end
    n_cmp++; if (rd_data !== 4'b0000) begin n_fail++; $display("FAIL alias_rd_after got %b exp 0000", rd_data); end
  endtask

  // Registers on entry: R0=0000 R1=1100 R2=0110 R3=0101
  task automatic test_back_to_back();
    logic [3:0] exp_res [3];
    logic [3:0] exp_rd [4];
    exp_res = '{4'b0011, 4'b0111, 4'b0011};
    exp_rd  = '{4'b0011, 4'b0111, 4'b0011, 4'b0101};
    for (int c = 0; c < 12; c++) begin
      cmd_valid = 1'b1;
      if (c == 0) begin
        cmd_load = 1'b1; cmd_op = 2'b00; cmd_dst = 2'd0; cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_imm = 4'b0011;
      end else if (c == 4) begin
        cmd_load = 1'b0; cmd_op = 2'b01; cmd_dst = 2'd1; cmd_srca = 2'd0; cmd_srcb = 2'd2; cmd_imm = 4'b1111;
      end else if (c == 8) begin
        cmd_load = 1'b0; cmd_op = 2'b00; cmd_dst = 2'd2; cmd_srca = 2'd1; cmd_srcb = 2'd0; cmd_imm = 4'b1111;
      end else begin
        cmd_load = 1'b1; cmd_op = 2'(c); cmd_dst = 2'd3; cmd_srca = 2'd3; cmd_srcb = 2'd3; cmd_imm = 4'b1111;
      end
      n_cmp++; if (cmd_ready !== ((c % 4) == 0)) begin n_fail++; $display("FAIL b2b_ready_c%0d got %b exp %b", c, cmd_ready, (c % 4) == 0); end
      n_cmp++; if (done !== ((c % 4) == 3)) begin n_fail++; $display("FAIL b2b_done_c%0d got %b exp %b", c, done, (c % 4) == 3); end
      if ((c % 4) == 3) begin
        n_cmp++; if (result !== exp_res[c / 4]) begin n_fail++; $display("FAIL b2b_result_c%0d got %b exp %b", c, result, exp_res[c / 4]); end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      n_cmp++; if (rd_data !== exp_rd[i]) begin n_fail++; $display("FAIL b2b_r%0d got %b exp %b", i, rd_data, exp_rd[i]); end
    end
  endtask

  task automatic test_reset_midop();
    int lat; logic [3:0] r; logic z; logic [3:0] o;
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, 2'b00, 2'd2, 2'd0, 2'd0, 4'b1111, lat, r, z, o);
      n_cmp++; if (rd_data !== 4'b1111) begin n_fail++; $display("FAIL rst%0d_preload got %b exp 1111", k, rd_data); end
      // AND R2 <= R0 & R1
      cmd_load = 1'b0; cmd_op = 2'b00; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd1;
      rd_addr = 2'd2;
      cmd_valid = 1'b1;
      @(negedge clk);               // READ
      cmd_valid = 1'b0;
      @(negedge clk);               // EXEC
      if (k == 1) begin
        @(negedge clk);             // WB
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst1_done_in_wb got %b exp 1", done); end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst%0d_done got %b exp 0", k, done); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst%0d_ready got %b exp 1", k, cmd_ready); end
      n_cmp++; if (rd_data !== 4'b0000) begin n_fail++; $display("FAIL rst%0d_r2 got %b exp 0000", k, rd_data); end
      n_cmp++; if (zero !== 1'b1 || result !== 4'b0000) begin n_fail++; $display("FAIL rst%0d_outputs got zero=%b result=%b exp 1 0000", k, zero, result); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst%0d_no_late_done got %b exp 0", k, done); end
      n_cmp++; if (rd_data !== 4'b0000) begin n_fail++; $display("FAIL rst%0d_r2_late got %b exp 0000", k, rd_data); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_load();
    test_logic_ops();
    test_alias();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
